// File: rtl/sn_bin_accum.sv
// Windowed stochastic-to-binary converter: counts ones over 2^WIN_LOG2 counted bits.
// Define SN_BIN_ACCUM_SAT_EN to saturate a full window of ones to all-ones instead of wrapping.
module sn_bin_accum #(
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear,
  input  logic                sn_in,
  input  logic                sn_valid,
  output logic                sn_ready,
  input  logic                gate,
  output logic [WIN_LOG2-1:0] res_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state;
  logic [WIN_LOG2-1:0] bit_cnt;
  logic [WIN_LOG2:0]   ones_cnt;
  logic [WIN_LOG2:0]   ones_next;
  logic [WIN_LOG2-1:0] res_next;
  logic                count_en;
  logic                last_bit;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    count_en  = (state == ACCUM) && sn_valid && gate;
    last_bit  = &bit_cnt;
    ones_next = ones_cnt + {{WIN_LOG2{1'b0}}, sn_in};
`ifdef SN_BIN_ACCUM_SAT_EN
    res_next  = ones_next[WIN_LOG2] ? '1 : ones_next[WIN_LOG2-1:0];
`else
    res_next  = ones_next[WIN_LOG2-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      sn_ready  <= 1'b0;
      busy      <= 1'b0;
    end else if (clear && (state != IDLE)) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      res_valid <= 1'b0;
      sn_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !clear) begin
            state    <= ACCUM;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            sn_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (count_en) begin
            bit_cnt  <= bit_cnt + 1'b1;
            ones_cnt <= ones_next;
            // Closing the window drops sn_ready in the same cycle res_valid rises.
            if (last_bit) begin
              state     <= DONE;
              res_data  <= res_next;
              res_valid <= 1'b1;
              sn_ready  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          sn_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sn_bin_accum.sv
// Self-checking bench for sn_bin_accum: directed test-plan scenarios plus random traffic,
// compared cycle by cycle against a window-counting reference model.
module tb_sn_bin_accum;

  localparam int W = 8;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic         sn_in = 1'b0;
  logic         sn_valid = 1'b0;
  logic         sn_ready;
  logic         gate = 1'b1;
  logic [W-1:0] res_data;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which phase of the window we are in, plus plain integer tallies.
  localparam int PH_IDLE = 0, PH_ACCUM = 1, PH_DONE = 2;
  int m_phase  = PH_IDLE;
  int m_taken  = 0;
  int m_ones   = 0;
  int m_result = 0;

  sn_bin_accum #(.WIN_LOG2(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .sn_in     (sn_in),
    .sn_valid  (sn_valid),
    .sn_ready  (sn_ready),
    .gate      (gate),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int window_result(input int ones);
`ifdef SN_BIN_ACCUM_SAT_EN
    return (ones > N - 1) ? N - 1 : ones;
`else
    return ones % N;
`endif
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = PH_IDLE; m_taken = 0; m_ones = 0; m_result = 0;
    end else if (clear && m_phase != PH_IDLE) begin
      m_phase = PH_IDLE; m_taken = 0; m_ones = 0;
    end else if (m_phase == PH_IDLE) begin
      if (start && !clear) begin
        m_phase = PH_ACCUM; m_taken = 0; m_ones = 0;
      end
    end else if (m_phase == PH_ACCUM) begin
      if (sn_valid && gate) begin
        m_taken++;
        m_ones += int'(sn_in);
        if (m_taken == N) begin
          m_result = window_result(m_ones);
          m_phase  = PH_DONE;
        end
      end
    end else if (res_ready) begin
      m_phase = PH_IDLE;
    end
  endtask

  // Apply one cycle of inputs, advance model at the edge, compare 1 time unit later.
  task automatic cycle(input logic s, input logic c, input logic r, input logic b,
                       input logic v, input logic g, input logic rr);
    start = s; clear = c; rst = r; sn_in = b; sn_valid = v; gate = g; res_ready = rr;
    @(posedge clk);
    model_step();
    #1;
    check("sn_ready",  int'(sn_ready),  int'(m_phase == PH_ACCUM));
    check("res_valid", int'(res_valid), int'(m_phase == PH_DONE));
    check("busy",      int'(busy),      int'(m_phase != PH_IDLE));
    if (m_phase == PH_DONE) check("res_data", int'(res_data), m_result);
  endtask

  task automatic do_reset();
    cycle(0, 0, 1, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0, 1, 0);
    check("rst_res_data", int'(res_data), 0);
  endtask

  initial begin
    do_reset();

    // 1: full window of ones
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) cycle(0, 0, 0, 1, 1, 1, 0);
`ifdef SN_BIN_ACCUM_SAT_EN
    check("full_ones", int'(res_data), 255);
`else
    check("full_ones", int'(res_data), 0);
`endif
    cycle(0, 0, 0, 0, 0, 1, 1);

    // 2: alternating 1,0
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) cycle(0, 0, 0, logic'(i % 2 == 0), 1, 1, 1);
    check("alt_data", int'(res_data), 8'h80);
    cycle(0, 0, 0, 0, 0, 1, 1);
    check("alt_idle", int'(busy), 0);

    // 3: valid every other cycle, one in every 4th accepted bit
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2 * N; i++)
      cycle(0, 0, 0, logic'((i / 2) % 4 == 3), logic'(i % 2 == 1), 1, 1);
    check("sparse_data", int'(res_data), 8'h40);
    cycle(0, 0, 0, 0, 0, 1, 1);

    // 4: 20 ungated ones mid-window, then stall the result with start and sn_valid high (5)
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N + 20; i++) begin
      if (i >= 128 && i < 148) cycle(0, 0, 0, 1, 1, 0, 0);
      else cycle(0, 0, 0, logic'((i < 128 ? i : i - 20) % 2 == 0), 1, 1, 0);
    end
    check("gate_data", int'(res_data), 8'h80);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 1, 1, 0);
    check("stall_data", int'(res_data), 8'h80);
    cycle(1, 0, 0, 1, 1, 1, 1);
    check("stall_release", int'(busy), 0);

    // 6: clear after 100 bits, then a window of zeros; then rst mid-window
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1, 1, 1, 0);
    cycle(0, 1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) cycle(0, 0, 0, 0, 1, 1, 0);
    check("zero_window", int'(res_data), 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1, 1, 1, 0);
    cycle(0, 0, 1, 0, 0, 1, 0);
    check("rst_mid_data", int'(res_data), 0);

    // Random traffic
    for (int i = 0; i < 5000; i++)
      cycle(logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 399) == 0),
            logic'($urandom_range(0, 1499) == 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 4) != 0),
            logic'($urandom_range(0, 9) != 0),
            logic'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
